// File: rtl/pass_through_pipe_if.sv
// Handshake bundle for pass_through_pipe: input side, output side,
// flush and occupancy. The pipe takes the slave view; the producer/consumer
// environment takes the master view.
interface pass_through_pipe_if #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             io_in_valid;
    logic             io_in_ready;
    logic [WIDTH-1:0] io_in_bits;
    logic             io_out_valid;
    logic             io_out_ready;
    logic [WIDTH-1:0] io_out_bits;
    logic             io_flush;
    logic [CW-1:0]    io_count;

    modport master (
        output io_in_valid, io_in_bits, io_out_ready, io_flush,
        input  io_in_ready, io_out_valid, io_out_bits, io_count
    );

    modport slave (
        input  io_in_valid, io_in_bits, io_out_ready, io_flush,
        output io_in_ready, io_out_valid, io_out_bits, io_count
    );
endinterface

// File: rtl/pass_through_pipe.sv
// Elastic WIDTH-bit, DEPTH-stage register pipeline with valid/ready on both
// sides. Empty stages always pull from their predecessor, so bubbles collapse
// and a full pipe with a ready consumer still moves one word per cycle.
// io_in_ready ripples combinationally back from io_out_ready; outputs are
// purely registered.
module pass_through_pipe #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 2
) (
    input logic clock,
    input logic reset,
    pass_through_pipe_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] src_v;
    logic [WIDTH-1:0] src_d [DEPTH];
    logic             accept;
    logic [CW-1:0]    cnt;

    // Ripple the "may move" condition from the output stage back to stage 0.
    always_comb begin
        logic rip;
        adv = '0;
        rip = bus.io_out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv[i] = rip;
            rip    = !v[i] || rip;
        end
    end

    assign load        = adv | ~v;
    assign bus.io_in_ready = !bus.io_flush && load[0];
    assign accept      = bus.io_in_valid && bus.io_in_ready;

    // Each stage's load source: the input port for stage 0, otherwise the previous stage.
    always_comb begin
        src_v    = '0;
        src_v[0] = accept;
        for (int i = 0; i < DEPTH; i++) src_d[i] = '0;
        src_d[0] = bus.io_in_bits;
        for (int i = 1; i < DEPTH; i++) begin
            src_v[i] = v[i-1];
            src_d[i] = d[i-1];
        end
    end

    // Stage registers: flush wins over every load; data only captured with a valid word,
    // so the output stage keeps its last value when it empties.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) d[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.io_flush) begin
                    v[i] <= 1'b0;
                end else if (load[i]) begin
                    v[i] <= src_v[i];
                    if (src_v[i]) d[i] <= src_d[i];
                end
            end
        end
    end

    // Occupancy is the number of valid stages.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) cnt = cnt + CW'(v[i]);
    end

    assign bus.io_out_valid = v[DEPTH-1];
    assign bus.io_out_bits  = d[DEPTH-1];
    assign bus.io_count     = cnt;

    // A producer holding a word that was not taken must keep it stable.
    a_producer_hold: assert property (
        @(posedge clock) disable iff (!reset)
        (bus.io_in_valid && !bus.io_in_ready) |=> (bus.io_in_valid && $stable(bus.io_in_bits))
    );
endmodule

// File: tb/tb_pass_through_pipe.sv
// Scoreboard bench for pass_through_pipe (WIDTH=10, DEPTH=3): words are pushed
// to an expected queue when accepted and popped when the DUT delivers them.
module tb_pass_through_pipe;
    localparam int WIDTH = 10;
    localparam int DEPTH = 3;

    logic clock;
    logic reset;

    pass_through_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) pif ();

    pass_through_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (pif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int mdl_count = 0;
    logic [WIDTH-1:0] src   [$];
    logic [WIDTH-1:0] exp_q [$];
    int               stamp_q [$];
    logic s_ready;
    logic popped;
    int   last_lat;
    int   last_pop_cyc;
    int   first_pop_cyc;
    bit   first;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // One clock cycle: drive from src, sample before the edge, update the model, return at negedge.
    task automatic step();
        logic acc, pop;
        pif.io_in_valid = (src.size() > 0);
        pif.io_in_bits  = (src.size() > 0) ? src[0] : '0;
        #1;
        s_ready = pif.io_in_ready;
        acc = pif.io_in_valid && pif.io_in_ready;
        pop = pif.io_out_valid && pif.io_out_ready;
        popped = pop;
        check("count", 32'(pif.io_count), 32'(mdl_count));
        if (pop) begin
            if (exp_q.size() == 0) begin
                check("out_unexpected", 32'(pif.io_out_valid), 32'd0);
            end else begin
                check("out_bits", 32'(pif.io_out_bits), 32'(exp_q.pop_front()));
                last_lat = cyc - stamp_q.pop_front();
                last_pop_cyc = cyc;
            end
        end
        if (acc) begin
            exp_q.push_back(pif.io_in_bits);
            stamp_q.push_back(cyc);
            void'(src.pop_front());
        end
        if (pif.io_flush) begin
            exp_q.delete();
            stamp_q.delete();
            mdl_count = 0;
        end else begin
            mdl_count = mdl_count + int'(acc) - int'(pop);
        end
        cyc++;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drain(input int max_cycles);
        for (int k = 0; k < max_cycles && (exp_q.size() > 0 || src.size() > 0); k++) step();
        check("drain_done", 32'(exp_q.size() + src.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held with a word offered
        reset = 1'b0;
        pif.io_flush     = 1'b0;
        pif.io_out_ready = 1'b0;
        pif.io_in_valid  = 1'b1;
        pif.io_in_bits   = 10'h3FF;
        repeat (3) @(negedge clock);
        #1;
        check("rst_out_valid", 32'(pif.io_out_valid), 32'd0);
        check("rst_out_bits",  32'(pif.io_out_bits),  32'd0);
        check("rst_count",     32'(pif.io_count),     32'd0);
        pif.io_in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_in_ready", 32'(pif.io_in_ready), 32'd1);
        @(negedge clock);

        // latency and streaming
        pif.io_out_ready = 1'b1;
        for (int w = 1; w <= 8; w++) src.push_back(WIDTH'(w));
        first = 1'b1;
        for (int k = 0; k < 40 && (src.size() > 0 || exp_q.size() > 0); k++) begin
            step();
            if (popped && first) begin
                check("latency", 32'(last_lat), 32'(DEPTH));
                first_pop_cyc = last_pop_cyc;
                first = 1'b0;
            end
        end
        check("stream_span", 32'(last_pop_cyc - first_pop_cyc), 32'd7);
        check("stream_drained", 32'(exp_q.size()), 32'd0);

        // backpressure
        pif.io_out_ready = 1'b0;
        src = '{10'h0A1, 10'h0A2, 10'h0A3, 10'h0A4};
        repeat (6) step();
        check("bp_count",    32'(pif.io_count),    32'd3);
        check("bp_in_ready", 32'(pif.io_in_ready), 32'd0);
        check("bp_held",     32'(src.size()),      32'd1);
        pif.io_out_ready = 1'b1;
        drain(20);

        // bubble collapse
        pif.io_out_ready = 1'b0;
        src = '{10'h055};
        repeat (3) step();
        src = '{10'h0AA};
        repeat (3) step();
        check("bub_count",     32'(pif.io_count),     32'd2);
        check("bub_out_valid", 32'(pif.io_out_valid), 32'd1);
        check("bub_out_bits",  32'(pif.io_out_bits),  32'h055);
        pif.io_out_ready = 1'b1;
        step();
        check("bub_b2b_valid", 32'(pif.io_out_valid), 32'd1);
        check("bub_b2b_bits",  32'(pif.io_out_bits),  32'h0AA);
        drain(10);

        // flush with a full pipe
        pif.io_out_ready = 1'b0;
        src = '{10'h111, 10'h222, 10'h333};
        repeat (4) step();
        check("fl_full", 32'(pif.io_count), 32'd3);
        pif.io_out_ready = 1'b1;
        pif.io_flush = 1'b1;
        src = '{10'h344};
        step();
        check("fl_in_ready", 32'(s_ready), 32'd0);
        check("fl_pop",      32'(popped),  32'd1);
        pif.io_flush = 1'b0;
        #1;
        check("fl_count",     32'(pif.io_count),     32'd0);
        check("fl_out_valid", 32'(pif.io_out_valid), 32'd0);
        drain(20);

        // asynchronous reset mid-stream
        pif.io_out_ready = 1'b0;
        src = '{10'h0B1, 10'h0B2};
        repeat (5) step();
        check("ar_count",     32'(pif.io_count),     32'd2);
        check("ar_out_valid", 32'(pif.io_out_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_drop_valid", 32'(pif.io_out_valid), 32'd0);
        check("ar_drop_count", 32'(pif.io_count),     32'd0);
        exp_q.delete();
        stamp_q.delete();
        src.delete();
        mdl_count = 0;
        pif.io_in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("ar_rel_ready", 32'(pif.io_in_ready),  32'd1);
        check("ar_rel_valid", 32'(pif.io_out_valid), 32'd0);
        @(negedge clock);
        pif.io_out_ready = 1'b1;
        src = '{10'h0C3};
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pass_through_pipe.md
# pass_through_pipe

Parametrised successor to the combinational pass-through: a WIDTH-bit, DEPTH-stage elastic pipeline with valid/ready handshakes on both sides, synchronous flush and an occupancy count. It sits between any producer and consumer in the bootcamp designs that need registered timing isolation or latency padding without losing data under backpressure. Every accepted word is delivered exactly once, in order and unmodified.

## Interface
Parameters:
- WIDTH, default 10: data width in bits, ≥1.
- DEPTH, default 2: number of register stages, ≥1.

Ports:
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; low clears all state immediately, release is synchronous to clock.
- io_in_valid  input  1  producer has a word on io_in_bits.
- io_in_ready  output  1  pipeline accepts io_in_bits this cycle.
- io_in_bits  input  WIDTH  input data.
- io_out_valid  output  1  last stage holds a word.
- io_out_ready  input  1  consumer takes io_out_bits this cycle.
- io_out_bits  output  WIDTH  last-stage data.
- io_flush  input  1  synchronous clear of all stages.
- io_count  output  clog2(DEPTH+1)  number of valid stages.

## Operation
- Stage i (0 = input side, DEPTH-1 = output side) holds v[i] and d[i].
- adv[DEPTH-1] = io_out_ready; for i<DEPTH-1, adv[i] = !v[i+1] || adv[i+1] (stage i may move when the next stage is empty or moving).
- io_in_ready = !io_flush && (!v[0] || adv[0]).
- Each edge, for each stage i: if adv[i] (or !v[i]), stage i loads from stage i-1 (or from the input for i=0): v[i] <= v[i-1] (resp. io_in_valid && io_in_ready), d[i] <= d[i-1] (resp. io_in_bits). Otherwise holds.
- Bubbles collapse: an empty stage always loads from its predecessor, so a word never waits behind an empty stage.
- Data registers load only when the incoming valid is 1; d of an empty stage is don't-care except d[DEPTH-1], which holds its last value.
- io_out_valid = v[DEPTH-1]; io_out_bits = d[DEPTH-1].
- io_count = popcount(v); ranges 0..DEPTH.
- io_flush high: on that edge all v[i] <= 0; no input accepted (io_in_ready=0); an output transfer in the same cycle (io_out_valid && io_out_ready) still counts as delivered. Flush takes priority over every load.
- Producer rule: once io_in_valid is high it holds io_in_valid and io_in_bits stable until accepted. The block checks this only in simulation assertions.
- Reset asserted mid-operation: all in-flight words discarded; no partial word emerges.

## Timing
- Reset values: io_out_valid=0, io_out_bits=0 (all d cleared), io_count=0, io_in_ready=1 (once reset released, io_flush low).
- Latency: word accepted on edge t into an empty pipe is on io_out_bits with io_out_valid=1 from edge t+DEPTH-1 (visible in the cycle after the edge at t+DEPTH-1 counting the accept edge as the first stage load), i.e. DEPTH cycles from io_in_valid&&io_in_ready to io_out_valid.
- Throughput: one word per cycle sustained when io_out_ready=1.
- Full (io_count=DEPTH) with io_out_ready=0: io_in_ready=0. Full with io_out_ready=1: io_in_ready=1, count unchanged (simultaneous push/pop).
- Empty: io_out_valid=0 regardless of io_out_ready.
- io_in_ready depends combinationally on io_out_ready and io_flush (ready ripple through DEPTH stages); io_out_valid/io_out_bits are purely registered.
- io_count updates on the edge after the transfer: +1 push only, −1 pop only, 0 both or neither, → 0 on flush.

## Test plan
- Reset: hold reset=0 with io_in_valid=1, io_in_bits=0x3FF -> io_out_valid=0, io_out_bits=0, io_count=0; after release io_in_ready=1.
- Latency/streaming (WIDTH=10, DEPTH=3): push 0x001..0x008 on consecutive cycles, io_out_ready=1 -> first word valid 3 cycles after accept, then 0x001..0x008 on consecutive cycles, io_count steady at 3.
- Backpressure: io_out_ready=0, push 0x0A1,0x0A2,0x0A3,0x0A4 -> first three accepted, io_count=3, io_in_ready=0 with 0x0A4 held; raise io_out_ready -> outputs 0x0A1,0x0A2,0x0A3,0x0A4 in order, no loss or duplicate.
- Bubble collapse: push 0x055, idle 2 cycles, push 0x0AA with io_out_ready=0 -> io_count=2 and both words adjacent at output stages; release -> 0x055 then 0x0AA back-to-back.
- Flush: full pipe (0x111,0x222,0x333), io_out_ready=1, assert io_flush one cycle with io_in_valid=1 -> 0x111 delivered that cycle, io_in_ready=0, next cycle io_count=0, io_out_valid=0; 0x222/0x333 never appear.
- Async reset mid-stream: assert reset between edges with io_count=2 -> io_out_valid drops to 0 immediately (before next edge); after release the pipeline restarts empty.
